// File: rtl/gv_pkg.sv
// Shared types and constants for the song sequencer / main_game interface.
package gv_pkg;

    localparam int unsigned DIFF_W = 23;
    localparam int unsigned LANE_W = 32;

    localparam logic [2:0] MODE_IDLE  = 3'd0;
    localparam logic [2:0] MODE_COUNT = 3'd1;
    localparam logic [2:0] MODE_PAUSE = 3'd2;
    localparam logic [2:0] MODE_DONE  = 3'd3;
    localparam logic [2:0] MODE_PLAY  = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH0,
        LOAD,
        COUNTDOWN,
        PLAY,
        PAUSED,
        DONE
    } seq_state_t;

    // One ROM word: two 32-note lanes, lane 2 in the upper half.
    typedef struct packed {
        logic [LANE_W-1:0] lane2;
        logic [LANE_W-1:0] lane1;
    } window_t;

    // Speed divider per difficulty level; larger level plays faster.
    function automatic logic [DIFF_W-1:0] diff_lookup(input logic [1:0] lvl);
        logic [DIFF_W-1:0] d;
        case (lvl)
            2'd0:    d = 23'd39;
            2'd1:    d = 23'd30;
            2'd2:    d = 23'd22;
            default: d = 23'd15;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pb_edge.sv
// Pushbutton synchroniser with a registered one-cycle rising-edge pulse.
module pb_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic [2:0] sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[1:0], btn};
            rise <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Play-session sequencer: ROM window fetch with one-deep prefetch, countdown,
// play/pause control and difficulty divider selection for main_game.
module song_sequencer
    import gv_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned STEP_CYCLES = 12_000_000,
    parameter int unsigned CD_STEPS    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                pause,
    input  logic [1:0]          level,
    input  logic [ADDR_W-1:0]   song_len,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [63:0]         rom_data,
    input  logic                word_done,
    output logic [LANE_W-1:0]   notes1,
    output logic [LANE_W-1:0]   notes2,
    output logic [DIFF_W-1:0]   diff,
    output logic [2:0]          mode,
    output logic [ADDR_W-1:0]   word_idx,
    output logic                song_over,
    output logic                underrun
);

    localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned CD_W   = (CD_STEPS > 1) ? $clog2(CD_STEPS) : 1;

    logic start_p, pause_p;

    pb_edge u_start_edge (.clk(clk), .reset(reset), .btn(start), .rise(start_p));
    pb_edge u_pause_edge (.clk(clk), .reset(reset), .btn(pause), .rise(pause_p));

    seq_state_t        state, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [1:0]        lvl_q, lvl_d;
    logic [ADDR_W-1:0] rom_addr_d, word_idx_d;
    logic [LANE_W-1:0] notes1_d, notes2_d;
    logic [DIFF_W-1:0] diff_d;
    logic [2:0]        mode_d;
    logic              song_over_d, underrun_d;
    window_t           shadow, shadow_d;
    logic              shadow_valid, shadow_valid_d;
    logic              pend1, pend1_d, pend2, pend2_d;
    logic [STEP_W-1:0] step_cnt, step_cnt_d;
    logic [CD_W-1:0]   cd_cnt, cd_cnt_d;
    window_t           rom_win;

    assign rom_win = window_t'(rom_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d        = state;
        len_d          = len_q;
        lvl_d          = lvl_q;
        rom_addr_d     = rom_addr;
        word_idx_d     = word_idx;
        notes1_d       = notes1;
        notes2_d       = notes2;
        diff_d         = diff;
        mode_d         = mode;
        song_over_d    = song_over;
        underrun_d     = underrun;
        shadow_d       = shadow;
        shadow_valid_d = shadow_valid;
        pend1_d        = 1'b0;
        pend2_d        = pend1;
        step_cnt_d     = step_cnt;
        cd_cnt_d       = cd_cnt;

        // ROM data for a new address lands two edges after the address update.
        if (pend2 && (rom_addr != len_q)) begin
            shadow_d       = rom_win;
            shadow_valid_d = 1'b1;
        end

        case (state)
            IDLE, DONE: begin
                if (start_p && (song_len != '0)) begin
                    len_d          = song_len;
                    lvl_d          = level;
                    rom_addr_d     = '0;
                    word_idx_d     = '0;
                    shadow_valid_d = 1'b0;
                    pend2_d        = 1'b0;
                    underrun_d     = 1'b0;
                    song_over_d    = 1'b0;
                    mode_d         = MODE_IDLE;
                    state_d        = FETCH0;
                end
            end
            FETCH0: state_d = LOAD;
            LOAD: begin
                notes1_d   = rom_win.lane1;
                notes2_d   = rom_win.lane2;
                word_idx_d = '0;
                diff_d     = diff_lookup(lvl_q);
                rom_addr_d = ADDR_W'(1);
                pend1_d    = 1'b1;
                step_cnt_d = '0;
                cd_cnt_d   = '0;
                mode_d     = MODE_COUNT;
                state_d    = COUNTDOWN;
            end
            COUNTDOWN: begin
                if (step_cnt == STEP_W'(STEP_CYCLES - 1)) begin
                    step_cnt_d = '0;
                    if (cd_cnt == CD_W'(CD_STEPS - 1)) begin
                        mode_d  = MODE_PLAY;
                        state_d = PLAY;
                    end else begin
                        cd_cnt_d = cd_cnt + CD_W'(1);
                    end
                end else begin
                    step_cnt_d = step_cnt + STEP_W'(1);
                end
            end
            PLAY: begin
                if (word_done && (word_idx == len_q - ADDR_W'(1))) begin
                    notes1_d    = '0;
                    notes2_d    = '0;
                    song_over_d = 1'b1;
                    mode_d      = MODE_DONE;
                    state_d     = DONE;
                end else begin
                    if (word_done) begin
                        if (shadow_valid) begin
                            notes1_d       = shadow.lane1;
                            notes2_d       = shadow.lane2;
                            word_idx_d     = word_idx + ADDR_W'(1);
                            rom_addr_d     = rom_addr + ADDR_W'(1);
                            shadow_valid_d = 1'b0;
                            pend1_d        = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end
                    if (pause_p) begin
                        mode_d  = MODE_PAUSE;
                        state_d = PAUSED;
                    end
                end
            end
            PAUSED: begin
                if (pause_p) begin
                    mode_d  = MODE_PLAY;
                    state_d = PLAY;
                end
            end
            default: begin
                mode_d  = MODE_IDLE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q        <= '0;
            lvl_q        <= '0;
            rom_addr     <= '0;
            word_idx     <= '0;
            notes1       <= '0;
            notes2       <= '0;
            diff         <= '0;
            mode         <= MODE_IDLE;
            song_over    <= 1'b0;
            underrun     <= 1'b0;
            shadow       <= '0;
            shadow_valid <= 1'b0;
            pend1        <= 1'b0;
            pend2        <= 1'b0;
            step_cnt     <= '0;
            cd_cnt       <= '0;
        end else begin
            len_q        <= len_d;
            lvl_q        <= lvl_d;
            rom_addr     <= rom_addr_d;
            word_idx     <= word_idx_d;
            notes1       <= notes1_d;
            notes2       <= notes2_d;
            diff         <= diff_d;
            mode         <= mode_d;
            song_over    <= song_over_d;
            underrun     <= underrun_d;
            shadow       <= shadow_d;
            shadow_valid <= shadow_valid_d;
            pend1        <= pend1_d;
            pend2        <= pend2_d;
            step_cnt     <= step_cnt_d;
            cd_cnt       <= cd_cnt_d;
        end
    end

endmodule
